// File: rtl/lock_controller.sv
// Water-lock chamber sequencer: opens the low/high gates, fills and drains the
// chamber, and times each fill/drain through an external countdown counter.
module lock_controller #(
    parameter int unsigned FILL_SEC  = 420,
    parameter int unsigned DRAIN_SEC = 480,
    parameter int unsigned EMPTY_SEC = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_low,
    input  logic       req_high,
    input  logic       occupied,
    input  logic       gate_close,
    input  logic       estop,
    input  logic [9:0] count_value,
    output logic       count_start,
    output logic [9:0] count_seconds,
    output logic       gate_low_open,
    output logic       gate_high_open,
    output logic       filling,
    output logic       draining,
    output logic [2:0] state
);

    localparam int unsigned CNT_W = 10;

    typedef enum logic [2:0] {
        LOW_IDLE   = 3'd0,
        LOW_OPEN   = 3'd1,
        LOAD_FILL  = 3'd2,
        FILL       = 3'd3,
        HIGH_IDLE  = 3'd4,
        HIGH_OPEN  = 3'd5,
        LOAD_DRAIN = 3'd6,
        DRAIN      = 3'd7
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   dur_q, dur_d;

    // State and duration registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= LOW_IDLE;
            dur_q   <= '0;
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
        end
    end

    // Next-state, duration selection and Moore output decode; estop freezes the sequence
    always_comb begin
        state_d        = state_q;
        dur_d          = dur_q;
        count_start    = 1'b0;
        count_seconds  = '0;
        gate_low_open  = 1'b0;
        gate_high_open = 1'b0;
        filling        = 1'b0;
        draining       = 1'b0;

        unique case (state_q)
            LOW_IDLE: begin
                if (!estop) begin
                    if (occupied) begin
                        state_d = LOAD_FILL;
                        dur_d   = CNT_W'(FILL_SEC);
                    end else if (req_low) begin
                        state_d = LOW_OPEN;
                    end else if (req_high) begin
                        state_d = LOAD_FILL;
                        dur_d   = CNT_W'(EMPTY_SEC);
                    end
                end
            end
            LOW_OPEN: begin
                gate_low_open = 1'b1;
                if (!estop && gate_close) begin
                    if (occupied) begin
                        state_d = LOAD_FILL;
                        dur_d   = CNT_W'(FILL_SEC);
                    end else begin
                        state_d = LOW_IDLE;
                    end
                end
            end
            LOAD_FILL: begin
                count_seconds = dur_q;
                if (!estop) state_d = FILL;
            end
            FILL: begin
                count_seconds = dur_q;
                count_start   = !estop;
                filling       = !estop;
                if (!estop && count_value == '0) begin
                    state_d = HIGH_OPEN;
                    dur_d   = '0;
                end
            end
            HIGH_IDLE: begin
                if (!estop) begin
                    if (occupied) begin
                        state_d = LOAD_DRAIN;
                        dur_d   = CNT_W'(DRAIN_SEC);
                    end else if (req_high) begin
                        state_d = HIGH_OPEN;
                    end else if (req_low) begin
                        state_d = LOAD_DRAIN;
                        dur_d   = CNT_W'(EMPTY_SEC);
                    end
                end
            end
            HIGH_OPEN: begin
                gate_high_open = 1'b1;
                if (!estop && gate_close) begin
                    if (occupied) begin
                        state_d = LOAD_DRAIN;
                        dur_d   = CNT_W'(DRAIN_SEC);
                    end else begin
                        state_d = HIGH_IDLE;
                    end
                end
            end
            LOAD_DRAIN: begin
                count_seconds = dur_q;
                if (!estop) state_d = DRAIN;
            end
            DRAIN: begin
                count_seconds = dur_q;
                count_start   = !estop;
                draining      = !estop;
                if (!estop && count_value == '0) begin
                    state_d = LOW_OPEN;
                    dur_d   = '0;
                end
            end
            default: begin
                state_d = LOW_IDLE;
                dur_d   = '0;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_lock_controller.sv
// Bench for lock_controller: behavioural countdown counter, state-transition
// scoreboard (expected state + cycle pushed at stimulus time), directed checks.
module tb_lock_controller;

    localparam logic [2:0] S_LOW_IDLE   = 3'd0;
    localparam logic [2:0] S_LOW_OPEN   = 3'd1;
    localparam logic [2:0] S_LOAD_FILL  = 3'd2;
    localparam logic [2:0] S_FILL       = 3'd3;
    localparam logic [2:0] S_HIGH_IDLE  = 3'd4;
    localparam logic [2:0] S_HIGH_OPEN  = 3'd5;
    localparam logic [2:0] S_LOAD_DRAIN = 3'd6;
    localparam logic [2:0] S_DRAIN      = 3'd7;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_low, req_high, occupied, gate_close, estop;
    logic [9:0] count_value;
    logic       count_start;
    logic [9:0] count_seconds;
    logic       gate_low_open, gate_high_open, filling, draining;
    logic [2:0] state;

    logic [9:0] cnt_q;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;
    logic [2:0] prev_state;

    typedef struct {
        logic [2:0] st;
        int         cyc;
    } exp_t;
    exp_t sb_q[$];

    lock_controller dut (
        .clk            (clk),
        .reset          (reset),
        .req_low        (req_low),
        .req_high       (req_high),
        .occupied       (occupied),
        .gate_close     (gate_close),
        .estop          (estop),
        .count_value    (count_value),
        .count_start    (count_start),
        .count_seconds  (count_seconds),
        .gate_low_open  (gate_low_open),
        .gate_high_open (gate_high_open),
        .filling        (filling),
        .draining       (draining),
        .state          (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Countdown counter: reload when idle at zero, pause when not started, else count down
    always @(posedge clk) begin
        if (!reset)                cnt_q <= count_seconds;
        else if (!count_start) begin
            if (cnt_q == 10'd0)    cnt_q <= count_seconds;
        end else if (cnt_q != 10'd0) cnt_q <= cnt_q - 10'd1;
    end
    assign count_value = cnt_q;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [2:0] st, input int c);
        exp_t e;
        e.st  = st;
        e.cyc = c;
        sb_q.push_back(e);
    endtask

    task automatic push_run(input logic [2:0] ld, input logic [2:0] run, input logic [2:0] fin,
                            input int e0, input int dur, input int extra);
        push(ld, e0);
        push(run, e0 + 1);
        push(fin, e0 + dur + 2 + extra);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n = 0;
        while (state !== st && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(state), 32'(st));
    endtask

    task automatic wait_count(input string tag, input logic [9:0] v, input int budget);
        int n = 0;
        while (count_value !== v && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(count_value), 32'(v));
    endtask

    // Scoreboard for state changes plus gate/valve exclusion on every cycle
    always @(negedge clk) begin
        if (mon_en) begin
            check("gate_excl", 32'((gate_low_open && gate_high_open) ||
                  ((gate_low_open || gate_high_open) && (filling || draining))), 32'd0);
            if (state !== prev_state) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_state", 32'(state), 32'(prev_state));
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_state", 32'(state), 32'(e.st));
                    check("sb_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            prev_state <= state;
        end
    end

    initial begin
        int e0, nd, bad;
        reset = 1'b0; req_low = 1'b0; req_high = 1'b0;
        occupied = 1'b0; gate_close = 1'b0; estop = 1'b0;

        // 1: reset held two cycles
        tick(2);
        check("rst_state", 32'(state), 32'd0);
        check("rst_outs", 32'({count_start, gate_low_open, gate_high_open, filling, draining}), 32'd0);
        check("rst_secs", 32'(count_seconds), 32'd0);
        check("rst_cnt", 32'(count_value), 32'd0);
        reset = 1'b1;
        prev_state = state;
        mon_en = 1'b1;

        // 2: boat from low side, fill 420
        req_low = 1'b1; push(S_LOW_OPEN, cyc + 1);
        tick(1);
        req_low = 1'b0; occupied = 1'b1;
        check("t2_low_gate", 32'(gate_low_open), 32'd1);
        tick(1);
        gate_close = 1'b1; e0 = cyc + 1;
        push_run(S_LOAD_FILL, S_FILL, S_HIGH_OPEN, e0, 420, 0);
        tick(1);
        gate_close = 1'b0;
        check("t2_load_secs", 32'(count_seconds), 32'd420);
        check("t2_load_start", 32'(count_start), 32'd0);
        tick(1);
        check("t2_fill_on", 32'({filling, count_start}), 32'd3);
        check("t2_cnt_loaded", 32'(count_value), 32'd420);
        wait_state("t2_high_open", S_HIGH_OPEN, 500);
        check("t2_high_gate", 32'(gate_high_open), 32'd1);

        // boat leaves, close high gate -> HIGH_IDLE
        occupied = 1'b0; gate_close = 1'b1; push(S_HIGH_IDLE, cyc + 1);
        tick(1);
        gate_close = 1'b0;

        // 3: empty drain requested from low side
        req_low = 1'b1; e0 = cyc + 1;
        push_run(S_LOAD_DRAIN, S_DRAIN, S_LOW_OPEN, e0, 300, 0);
        tick(1);
        req_low = 1'b0;
        check("t3_load_secs", 32'(count_seconds), 32'd300);
        nd = 0; bad = 0;
        for (int i = 0; i < 400 && state !== S_LOW_OPEN; i++) begin
            tick(1);
            if (state === S_DRAIN) begin
                nd++;
                if (draining !== 1'b1) bad++;
            end
        end
        check("t3_drain_bad", 32'(bad), 32'd0);
        check("t3_drain_cycles", 32'(nd), 32'd301);
        check("t3_low_open", 32'(state), 32'(S_LOW_OPEN));

        // 5: both requests in LOW_IDLE, low wins; gate_close and requests in FILL ignored
        gate_close = 1'b1; push(S_LOW_IDLE, cyc + 1);
        tick(1);
        gate_close = 1'b0;
        req_low = 1'b1; req_high = 1'b1; push(S_LOW_OPEN, cyc + 1);
        tick(1);
        req_low = 1'b0; req_high = 1'b0;
        check("t5_low_prio", 32'(gate_low_open), 32'd1);
        occupied = 1'b1; gate_close = 1'b1; e0 = cyc + 1;
        push_run(S_LOAD_FILL, S_FILL, S_HIGH_OPEN, e0, 420, 0);
        tick(1);
        gate_close = 1'b0;
        tick(100);
        gate_close = 1'b1; req_low = 1'b1;
        tick(1);
        gate_close = 1'b0; req_low = 1'b0;
        check("t5_close_ignored", 32'(state), 32'(S_FILL));
        wait_state("t5_high_open", S_HIGH_OPEN, 500);

        // 4: loaded drain with 50-cycle estop at count 200
        gate_close = 1'b1; e0 = cyc + 1;
        push_run(S_LOAD_DRAIN, S_DRAIN, S_LOW_OPEN, e0, 480, 50);
        tick(1);
        gate_close = 1'b0;
        wait_count("t4_reach_200", 10'd200, 500);
        estop = 1'b1;
        #1;
        check("t4_estop_drain_off", 32'({draining, count_start}), 32'd0);
        tick(50);
        check("t4_held_cnt", 32'(count_value), 32'd200);
        check("t4_held_state", 32'(state), 32'(S_DRAIN));
        estop = 1'b0;
        #1;
        check("t4_resume", 32'(draining), 32'd1);
        wait_state("t4_low_open", S_LOW_OPEN, 400);

        // 6: reset in the middle of a fill
        gate_close = 1'b1; e0 = cyc + 1;
        push(S_LOAD_FILL, e0); push(S_FILL, e0 + 1);
        tick(1);
        gate_close = 1'b0;
        wait_count("t6_reach_100", 10'd100, 500);
        reset = 1'b0; push(S_LOW_IDLE, cyc + 1);
        tick(2);
        check("t6_state", 32'(state), 32'd0);
        check("t6_secs", 32'(count_seconds), 32'd0);
        check("t6_cnt", 32'(count_value), 32'd0);
        reset = 1'b1; occupied = 1'b0;
        tick(5);
        check("t6_no_stale", 32'({state, count_value}), 32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
